// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that merges P_CH_NUM byte streams into one uart_tx user port.
// A grant is held for a whole packet (until last) or P_MAX_BURST bytes, whichever
// comes first. A single output register feeds the UART.

// Per-channel slice: gates the channel's request by its grant bit so that the top
// level can OR-reduce all lanes into the granted channel's view.
module uart_tx_arb_lane #(
    parameter int W = 8
) (
    input  logic         grant,
    input  logic         xfer_free,
    input  logic [W-1:0] req_data,
    input  logic         req_valid,
    input  logic         req_last,
    output logic         req_ready,
    output logic [W-1:0] sel_data,
    output logic         sel_valid,
    output logic         sel_last
);
    assign req_ready = grant & xfer_free;
    assign sel_data  = grant ? req_data : '0;
    assign sel_valid = grant & req_valid;
    assign sel_last  = grant & req_last;
endmodule

module uart_tx_arbiter #(
    parameter int P_UART_DATA_WIDTH = 8,
    parameter int P_CH_NUM          = 4,
    parameter int P_MAX_BURST       = 16
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic [P_CH_NUM*P_UART_DATA_WIDTH-1:0] i_req_data,
    input  logic [P_CH_NUM-1:0]                   i_req_valid,
    input  logic [P_CH_NUM-1:0]                   i_req_last,
    output logic [P_CH_NUM-1:0]                   o_req_ready,
    output logic [P_UART_DATA_WIDTH-1:0]          o_tx_data,
    output logic                                  o_tx_valid,
    input  logic                                  i_tx_ready,
    output logic [P_CH_NUM-1:0]                   o_grant,
    output logic                                  o_busy
);
    localparam int W  = P_UART_DATA_WIDTH;
    localparam int IW = $clog2(P_CH_NUM);
    localparam int CW = $clog2(P_MAX_BURST + 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t                       state_q, state_d;
    logic [IW-1:0]                rr_ptr_q, gnt_idx_q, sel_idx;
    logic                         sel_found;
    logic [CW-1:0]                cnt_q, cnt_inc;
    logic                         stage_free, xfer_free, acc, pkt_end;
    logic [P_CH_NUM-1:0]          lane_valid, lane_last;
    logic [P_CH_NUM-1:0][W-1:0]   lane_data;
    logic [W-1:0]                 g_data;
    logic                         g_valid, g_last;

    // Output register can take a new byte when empty or being drained this cycle.
    assign stage_free = !o_tx_valid || i_tx_ready;
    assign xfer_free  = (state_q == XFER) && stage_free;

    for (genvar k = 0; k < P_CH_NUM; k++) begin : g_lane
        uart_tx_arb_lane #(.W(W)) u_lane (
            .grant     (o_grant[k]),
            .xfer_free (xfer_free),
            .req_data  (i_req_data[k*W +: W]),
            .req_valid (i_req_valid[k]),
            .req_last  (i_req_last[k]),
            .req_ready (o_req_ready[k]),
            .sel_data  (lane_data[k]),
            .sel_valid (lane_valid[k]),
            .sel_last  (lane_last[k])
        );
    end

    // Collapse the one-hot-gated lanes into the granted channel's signals.
    always_comb begin
        g_data = '0;
        for (int k = 0; k < P_CH_NUM; k++) g_data = g_data | lane_data[k];
        g_valid = |lane_valid;
        g_last  = |lane_last;
    end

    assign acc     = xfer_free && g_valid;
    assign cnt_inc = cnt_q + CW'(1);
    assign pkt_end = acc && (g_last || (cnt_inc == CW'(P_MAX_BURST)));

    // Round-robin search: first valid channel at or above rr_ptr, wrapping.
    always_comb begin
        int cand;
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int i = 0; i < P_CH_NUM; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= P_CH_NUM) cand = cand - P_CH_NUM;
            if (!sel_found && i_req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(cand);
            end
        end
    end

    // Next-state: arbitrate in IDLE, leave XFER at packet end or burst cap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sel_found) state_d = XFER;
            XFER:    if (pkt_end)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Grant, round-robin pointer and burst counter.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_grant   <= '0;
            gnt_idx_q <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
        end else if (state_q == IDLE) begin
            if (sel_found) begin
                o_grant   <= P_CH_NUM'(1) << sel_idx;
                gnt_idx_q <= sel_idx;
                cnt_q     <= '0;
            end
        end else begin
            if (acc && (cnt_q != CW'(P_MAX_BURST))) cnt_q <= cnt_inc;
            if (pkt_end) begin
                o_grant  <= '0;
                rr_ptr_q <= (gnt_idx_q == IW'(P_CH_NUM - 1)) ? '0 : gnt_idx_q + IW'(1);
            end
        end
    end

    // Output stage: load on accept, drain when the UART takes the byte, else hold.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_tx_data  <= '0;
            o_tx_valid <= 1'b0;
        end else if (acc) begin
            o_tx_data  <= g_data;
            o_tx_valid <= 1'b1;
        end else if (i_tx_ready) begin
            o_tx_valid <= 1'b0;
        end
    end

    assign o_busy = (state_q != IDLE) || o_tx_valid;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter, 4 channels, burst cap of 4.
module tb_uart_tx_arbiter;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [31:0] i_req_data;
    logic [3:0]  i_req_valid, i_req_last, o_req_ready, o_grant;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid, i_tx_ready, o_busy;

    int total = 0;
    int passed = 0;

    uart_tx_arbiter #(.P_UART_DATA_WIDTH(8), .P_CH_NUM(4), .P_MAX_BURST(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req_data(i_req_data), .i_req_valid(i_req_valid),
        .i_req_last(i_req_last), .o_req_ready(o_req_ready), .o_tx_data(o_tx_data),
        .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready), .o_grant(o_grant), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_ch(input int k, input logic [7:0] d, input logic v, input logic l);
        i_req_data[k*8 +: 8] = d;
        i_req_valid[k] = v;
        i_req_last[k]  = l;
    endtask

    initial begin
        i_rst = 1'b0; i_req_data = '0; i_req_valid = '0; i_req_last = '0; i_tx_ready = 1'b1;
        #3;
        chk("rst_grant", o_grant, 0);
        chk("rst_ready", o_req_ready, 0);
        chk("rst_txv", o_tx_valid, 0);
        chk("rst_txd", o_tx_data, 0);
        chk("rst_busy", o_busy, 0);
        step(); step();
        i_rst = 1'b1;
        step();

        // Single channel, two-byte packet on ch1.
        set_ch(1, 8'hA5, 1'b1, 1'b0);
        #1 chk("a_idle_grant", o_grant, 0);
        step();
        chk("a_grant", o_grant, 4'b0010);
        chk("a_ready", o_req_ready, 4'b0010);
        chk("a_txv0", o_tx_valid, 0);
        step();
        chk("a_d0", o_tx_data, 8'hA5);
        chk("a_v0", o_tx_valid, 1);
        set_ch(1, 8'h5A, 1'b1, 1'b1);
        #1 chk("a_ready1", o_req_ready, 4'b0010);
        step();
        chk("a_d1", o_tx_data, 8'h5A);
        chk("a_gclr", o_grant, 0);
        set_ch(1, 8'h00, 1'b0, 1'b0);
        chk("a_busy", o_busy, 1);
        step();
        chk("a_txv_clr", o_tx_valid, 0);
        chk("a_busy_clr", o_busy, 0);

        // Round-robin from reset, all channels with 1-byte packets.
        i_rst = 1'b0; #1 i_rst = 1'b1;
        for (int k = 0; k < 4; k++) set_ch(k, 8'hC0 + 8'(k), 1'b1, 1'b1);
        begin
            int order [5] = '{0, 1, 2, 3, 0};
            for (int j = 0; j < 5; j++) begin
                step();
                chk("rr_grant", o_grant, 32'(1) << order[j]);
                step();
                chk("rr_data", o_tx_data, 32'hC0 + order[j]);
                chk("rr_gclr", o_grant, 0);
            end
        end
        i_req_valid = '0; i_req_last = '0;
        step(); step();

        // Backpressure on ch3 (pointer now at 1).
        set_ch(3, 8'h11, 1'b1, 1'b0);
        step();
        chk("bp_grant", o_grant, 4'b1000);
        step();
        chk("bp_d0", o_tx_data, 8'h11);
        i_tx_ready = 1'b0;
        set_ch(3, 8'h22, 1'b1, 1'b0);
        for (int j = 0; j < 10; j++) begin
            #1;
            chk("bp_hold_v", o_tx_valid, 1);
            chk("bp_hold_d", o_tx_data, 8'h11);
            chk("bp_hold_rdy", o_req_ready, 0);
            step();
        end
        i_tx_ready = 1'b1;
        set_ch(3, 8'h22, 1'b1, 1'b1);
        #1 chk("bp_resume_rdy", o_req_ready, 4'b1000);
        step();
        chk("bp_d1", o_tx_data, 8'h22);
        chk("bp_gclr", o_grant, 0);
        set_ch(3, 8'h00, 1'b0, 1'b0);
        step();

        // Burst cap: ch2 streams without last, ch3 waiting (pointer at 0).
        set_ch(2, 8'h20, 1'b1, 1'b0);
        set_ch(3, 8'h33, 1'b1, 1'b1);
        step();
        chk("bc_grant2", o_grant, 4'b0100);
        for (int j = 0; j < 4; j++) begin
            step();
            chk("bc_data", o_tx_data, 32'h20 + j);
            set_ch(2, 8'h21 + 8'(j), 1'b1, 1'b0);
        end
        chk("bc_cap_gclr", o_grant, 0);
        step();
        chk("bc_grant3", o_grant, 4'b1000);
        step();
        chk("bc_d3", o_tx_data, 8'h33);
        set_ch(3, 8'h00, 1'b0, 1'b0);
        step();
        chk("bc_regrant2", o_grant, 4'b0100);
        step();
        chk("bc_d4", o_tx_data, 8'h24);
        set_ch(2, 8'h25, 1'b1, 1'b1);
        step();
        chk("bc_d5", o_tx_data, 8'h25);
        chk("bc_end_gclr", o_grant, 0);
        set_ch(2, 8'h00, 1'b0, 1'b0);
        step();

        // Stall: ch0 drops valid mid-packet while ch1 waits (pointer at 3).
        set_ch(0, 8'h40, 1'b1, 1'b0);
        set_ch(1, 8'h51, 1'b1, 1'b1);
        step();
        chk("st_grant", o_grant, 4'b0001);
        step();
        chk("st_d0", o_tx_data, 8'h40);
        set_ch(0, 8'h00, 1'b0, 1'b0);
        for (int j = 0; j < 5; j++) begin
            step();
            chk("st_hold_grant", o_grant, 4'b0001);
            chk("st_hold_data", o_tx_data, 8'h40);
            chk("st_hold_v", o_tx_valid, 0);
        end
        set_ch(0, 8'h41, 1'b1, 1'b1);
        step();
        chk("st_d1", o_tx_data, 8'h41);
        set_ch(0, 8'h00, 1'b0, 1'b0);
        step();
        chk("st_grant1", o_grant, 4'b0010);
        step();
        chk("st_d_ch1", o_tx_data, 8'h51);
        set_ch(1, 8'h00, 1'b0, 1'b0);
        step();

        // Move pointer to 3 with a one-byte packet on ch2.
        set_ch(2, 8'h5F, 1'b1, 1'b1);
        step();
        chk("pre_grant2", o_grant, 4'b0100);
        step();
        set_ch(2, 8'h00, 1'b0, 1'b0);
        step();

        // Reset mid-packet on ch3, then arbitration restarts from channel 0.
        set_ch(3, 8'h61, 1'b1, 1'b0);
        step();
        chk("rm_grant3", o_grant, 4'b1000);
        step();
        chk("rm_txv", o_tx_valid, 1);
        i_rst = 1'b0;
        #1;
        chk("rm_grant0", o_grant, 0);
        chk("rm_ready0", o_req_ready, 0);
        chk("rm_txv0", o_tx_valid, 0);
        chk("rm_txd0", o_tx_data, 0);
        chk("rm_busy0", o_busy, 0);
        set_ch(2, 8'h72, 1'b1, 1'b1);
        #1 i_rst = 1'b1;
        step();
        chk("rm_grant_ch2", o_grant, 4'b0100);
        step();
        chk("rm_d", o_tx_data, 8'h72);
        i_req_valid = '0; i_req_last = '0;
        step(); step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter P_UART_DATA_WIDTH, default 8, byte width of each channel and of the uart_tx user port.
REQ-002 Parameter P_CH_NUM, default 4, number of requesters; legal range 2..8.
REQ-003 Parameter P_MAX_BURST, default 16, maximum bytes per grant before forced rotation; legal range 1..255.
REQ-004 i_clk  input  1  sole clock; all state changes on rising edge.
REQ-005 i_rst  input  1  reset, asynchronous assert, active-low (0 = reset), synchronous deassert by the system.
REQ-006 i_req_data  input  P_CH_NUM*P_UART_DATA_WIDTH  channel k byte at bits [k*W +: W].
REQ-007 i_req_valid  input  P_CH_NUM  per-channel byte valid.
REQ-008 i_req_last  input  P_CH_NUM  per-channel end-of-packet flag, qualified by valid.
REQ-009 o_req_ready  output  P_CH_NUM  per-channel byte accept.
REQ-010 o_tx_data  output  P_UART_DATA_WIDTH  byte to uart_tx i_user_tx_data.
REQ-011 o_tx_valid  output  1  to uart_tx i_user_tx_valid.
REQ-012 i_tx_ready  input  1  from uart_tx o_user_tx_ready.
REQ-013 o_grant  output  P_CH_NUM  one-hot current owner; all-zero when no owner.
REQ-014 o_busy  output  1  high when state is not IDLE or o_tx_valid is high.

Function
REQ-015 Transfer on any port occurs only in a cycle where valid and ready are both high.
REQ-016 FSM states IDLE and XFER; reset state IDLE.
REQ-017 IDLE: if any i_req_valid high, select the first valid channel searching from rr_ptr upward modulo P_CH_NUM, register it in o_grant, clear burst counter, go to XFER next cycle; otherwise stay IDLE.
REQ-018 rr_ptr resets to 0; on leaving XFER it becomes (granted index + 1) mod P_CH_NUM.
REQ-019 Output stage is one register (o_tx_data/o_tx_valid); it is "free" when o_tx_valid=0 or i_tx_ready=1.
REQ-020 XFER: o_req_ready[g] = output stage free, g = granted channel; all other o_req_ready bits 0; in IDLE all bits 0.
REQ-021 Accepted byte loads o_tx_data and sets o_tx_valid=1 next cycle; o_tx_valid clears only when i_tx_ready=1 and no byte accepted that cycle.
REQ-022 o_tx_data/o_tx_valid hold stable while o_tx_valid=1 and i_tx_ready=0.
REQ-023 Burst counter, width clog2(P_MAX_BURST+1), increments per accepted byte; never wraps.
REQ-024 XFER exits to IDLE (o_grant cleared next cycle) on the cycle a byte is accepted with i_req_last[g]=1 or the counter reaches P_MAX_BURST with that byte.
REQ-025 Granted channel deasserting valid mid-packet: grant held, no timeout, no rotation.
REQ-026 Latency: valid first seen in IDLE at cycle N -> o_grant at N+1, o_req_ready[g] at N+1 (stage free), o_tx_valid at N+2.
REQ-027 Throughput: with i_tx_ready held 1 and valid held, one byte per clock within a grant; one idle arbitration cycle between grants.
REQ-028 Byte order into uart_tx equals acceptance order; no byte is dropped or duplicated.
REQ-029 Non-granted channels' valid/data/last are ignored; a channel holding valid keeps its request pending.

Reset
REQ-030 i_rst=0 forces immediately: state IDLE, o_grant=0, o_req_ready=0, o_tx_valid=0, o_tx_data=0, rr_ptr=0, counter=0, o_busy=0.
REQ-031 Reset mid-packet discards the output-stage byte and the grant; after release arbitration restarts from channel 0.

Verification
REQ-032 Single channel: ch1 sends 0xA5,0x5A (last on 2nd), i_tx_ready=1 -> o_grant=4'b0010 one cycle after valid, o_tx_data 0xA5 then 0x5A on consecutive cycles, grant clears after 0x5A accepted.
REQ-033 Round-robin: ch0..ch3 all valid with 1-byte packets (last=1) from reset -> grant order 0,1,2,3,0; ch0 second grant only after ch3.
REQ-034 Backpressure: i_tx_ready=0 for 10 cycles after first byte 0x11 -> o_tx_valid=1, o_tx_data=0x11 stable, o_req_ready[g]=0 throughout; resumes on i_tx_ready=1.
REQ-035 Burst cap: P_MAX_BURST=4, ch2 streams 6 bytes without last, ch3 valid -> 4 bytes from ch2, then ch3 granted, then ch2 gets remaining 2.
REQ-036 Stall: ch0 granted, valid drops 5 cycles mid-packet while ch1 valid -> o_grant stays 0001, no ch1 byte emitted.
REQ-037 Reset mid-op: i_rst=0 while o_tx_valid=1 -> all outputs 0 same cycle; after release with ch2 valid, grant goes to ch2 (search from 0).
